// File: rtl/wb_pkg.sv
// Shared types and constants for the RV32 writeback controller.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int PCW  = 10;
  localparam int RAW  = 5;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_ctrl_if.sv
// Bundle of issue, data-memory and register-file write signals around wb_ctrl.
interface wb_ctrl_if;
  import wb_pkg::*;

  logic            issue_valid;
  logic            issue_ready;
  logic [1:0]      mem_to_reg;
  logic            reg_write;
  logic [RAW-1:0]  rd;
  logic [XLEN-1:0] alu_result;
  logic [PCW-1:0]  pc_4;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_we;
  logic [RAW-1:0]  rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            stall;
  logic            err;

  modport master (
    output issue_valid, mem_to_reg, reg_write, rd, alu_result, pc_4,
    output mem_rvalid, mem_rdata,
    input  issue_ready, mem_req, mem_addr, rf_we, rf_waddr, rf_wdata, stall, err
  );

  modport slave (
    input  issue_valid, mem_to_reg, reg_write, rd, alu_result, pc_4,
    input  mem_rvalid, mem_rdata,
    output issue_ready, mem_req, mem_addr, rf_we, rf_waddr, rf_wdata, stall, err
  );

endinterface

// File: rtl/wb_select.sv
// Combinational writeback value select: ALU result, load data or zero-extended PC+4.
module wb_select
  import wb_pkg::*;
(
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_mem,
  input  logic [PCW-1:0]  i_pc4,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_alu;
    case (i_sel)
      WB_SEL_ALU:       o_data = i_alu;
      WB_SEL_MEM:       o_data = i_mem;
      WB_SEL_PC4, 2'd3: o_data = {{(XLEN-PCW){1'b0}}, i_pc4};
      default:          o_data = i_alu;
    endcase
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: selects rf write data and sequences variable-latency loads.
// Optional load timeout enabled by defining WB_CTRL_TIMEOUT_EN.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_ctrl_if.slave bus
);

  wb_state_e       r_state;
  logic            r_mem_req_p1;
  logic [XLEN-1:0] r_mem_addr_p1;
  logic            r_rf_we_p1;
  logic [RAW-1:0]  r_rf_waddr_p1;
  logic [XLEN-1:0] r_rf_wdata_p1;
  logic [RAW-1:0]  r_ld_rd;
  logic            r_ld_we;
  logic [1:0]      w_sel;
  logic [XLEN-1:0] w_wdata;

`ifdef WB_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] r_cnt;
  logic          r_err_p1;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  // While waiting on memory the only possible write source is the load data.
  assign w_sel = (r_state == MEM_WAIT) ? WB_SEL_MEM : bus.mem_to_reg;

  wb_select u_sel (
    .i_sel  (w_sel),
    .i_alu  (bus.alu_result),
    .i_mem  (bus.mem_rdata),
    .i_pc4  (bus.pc_4),
    .o_data (w_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mem_req_p1  <= 1'b0;
      r_mem_addr_p1 <= '0;
      r_rf_we_p1    <= 1'b0;
      r_rf_waddr_p1 <= '0;
      r_rf_wdata_p1 <= '0;
      r_ld_rd       <= '0;
      r_ld_we       <= 1'b0;
`ifdef WB_CTRL_TIMEOUT_EN
      r_cnt         <= '0;
      r_err_p1      <= 1'b0;
`endif
    end else begin
      r_rf_we_p1 <= 1'b0;
`ifdef WB_CTRL_TIMEOUT_EN
      r_err_p1   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.issue_valid) begin
            if (bus.mem_to_reg == WB_SEL_MEM) begin
              r_ld_rd       <= bus.rd;
              r_ld_we       <= bus.reg_write;
              r_mem_addr_p1 <= bus.alu_result;
              r_mem_req_p1  <= 1'b1;
              r_state       <= MEM_WAIT;
`ifdef WB_CTRL_TIMEOUT_EN
              r_cnt         <= '0;
`endif
            end else begin
              r_rf_we_p1    <= bus.reg_write && (bus.rd != '0);
              r_rf_waddr_p1 <= bus.rd;
              r_rf_wdata_p1 <= w_wdata;
            end
          end
        end
        MEM_WAIT: begin
          if (bus.mem_rvalid) begin
            r_rf_we_p1    <= r_ld_we && (r_ld_rd != '0);
            r_rf_waddr_p1 <= r_ld_rd;
            r_rf_wdata_p1 <= w_wdata;
            r_mem_req_p1  <= 1'b0;
            r_state       <= IDLE;
          end
`ifdef WB_CTRL_TIMEOUT_EN
          // Abandon the load once mem_req has been up for TIMEOUT cycles.
          else if (r_cnt == LAST) begin
            r_err_p1     <= 1'b1;
            r_mem_req_p1 <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready = (r_state == IDLE);
  assign bus.stall       = (r_state == MEM_WAIT);
  assign bus.mem_req     = r_mem_req_p1;
  assign bus.mem_addr    = r_mem_addr_p1;
  assign bus.rf_we       = r_rf_we_p1;
  assign bus.rf_waddr    = r_rf_waddr_p1;
  assign bus.rf_wdata    = r_rf_wdata_p1;
`ifdef WB_CTRL_TIMEOUT_EN
  assign bus.err         = r_err_p1;
`else
  assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: vector table for ALU/PC+4 writes, scripted load sequences.
module tb_wb_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nbad = 0;

  wb_ctrl_if u_if ();

  wb_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [9:0]  pc4;
    logic        we;
    logic [31:0] wdata;
  } vec_t;

  wr_t  sb_q[$];
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every rf write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (u_if.rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        ncmp++;
        nbad++;
        $display("FAIL unexpected_rf_we waddr=%0d wdata=%0h required=no write", u_if.rf_waddr, u_if.rf_wdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("sb_rf_waddr", 32'(u_if.rf_waddr), 32'(e.a));
        chk("sb_rf_wdata", u_if.rf_wdata, e.d);
      end
    end
  end

  task automatic start_load(input logic [31:0] addr, input logic [4:0] rd, input logic rw);
    u_if.issue_valid = 1'b1;
    u_if.mem_to_reg  = 2'd1;
    u_if.alu_result  = addr;
    u_if.rd          = rd;
    u_if.reg_write   = rw;
    @(posedge clk);
    @(negedge clk);
    u_if.issue_valid = 1'b0;
    u_if.mem_to_reg  = 2'd0;
  endtask

  initial begin
    int nreq;
    int nerr;
    rst_n            = 1'b0;
    u_if.issue_valid = 1'b0;
    u_if.mem_to_reg  = 2'd0;
    u_if.reg_write   = 1'b0;
    u_if.rd          = '0;
    u_if.alu_result  = '0;
    u_if.pc_4        = '0;
    u_if.mem_rvalid  = 1'b0;
    u_if.mem_rdata   = '0;

    tbl[0] = '{2'd0, 1'b1, 5'd5,  32'd15,         10'd0,   1'b1, 32'd15};
    tbl[1] = '{2'd2, 1'b1, 5'd3,  32'h1234,       10'd4,   1'b1, 32'd4};
    tbl[2] = '{2'd3, 1'b1, 5'd3,  32'h5678,       10'd4,   1'b1, 32'd4};
    tbl[3] = '{2'd0, 1'b1, 5'd0,  32'h55,         10'd0,   1'b0, 32'h0};
    tbl[4] = '{2'd0, 1'b0, 5'd9,  32'h66,         10'd0,   1'b0, 32'h0};
    tbl[5] = '{2'd0, 1'b1, 5'd31, 32'hFFFF_FFFF,  10'd8,   1'b1, 32'hFFFF_FFFF};
    tbl[6] = '{2'd2, 1'b1, 5'd1,  32'hDEAD_BEEF,  10'h3FF, 1'b1, 32'h0000_03FF};

    repeat (2) @(negedge clk);
    chk("rst_issue_ready", 32'(u_if.issue_ready), 32'd1);
    chk("rst_stall",       32'(u_if.stall),       32'd0);
    chk("rst_mem_req",     32'(u_if.mem_req),     32'd0);
    chk("rst_mem_addr",    u_if.mem_addr,         32'd0);
    chk("rst_rf_we",       32'(u_if.rf_we),       32'd0);
    chk("rst_rf_waddr",    32'(u_if.rf_waddr),    32'd0);
    chk("rst_rf_wdata",    u_if.rf_wdata,         32'd0);
    chk("rst_err",         32'(u_if.err),         32'd0);
    rst_n = 1'b1;

    // Back-to-back non-load writes.
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      u_if.issue_valid = 1'b1;
      u_if.mem_to_reg  = tbl[i].sel;
      u_if.reg_write   = tbl[i].rw;
      u_if.rd          = tbl[i].rd;
      u_if.alu_result  = tbl[i].alu;
      u_if.pc_4        = tbl[i].pc4;
      @(posedge clk);
      if (tbl[i].we) sb_q.push_back('{a: tbl[i].rd, d: tbl[i].wdata});
      @(negedge clk);
      chk($sformatf("vec%0d_rf_we", i), 32'(u_if.rf_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_issue_ready", i), 32'(u_if.issue_ready), 32'd1);
    end
    u_if.issue_valid = 1'b0;
    @(negedge clk);
    chk("idle_rf_we", 32'(u_if.rf_we), 32'd0);

    // Load with three MEM_WAIT cycles.
    start_load(32'h40, 5'd7, 1'b1);
    chk("ld_mem_req",     32'(u_if.mem_req),     32'd1);
    chk("ld_mem_addr",    u_if.mem_addr,         32'h40);
    chk("ld_stall",       32'(u_if.stall),       32'd1);
    chk("ld_issue_ready", 32'(u_if.issue_ready), 32'd0);
    chk("ld_rf_we_wait",  32'(u_if.rf_we),       32'd0);
    @(negedge clk);
    chk("ld_stall2", 32'(u_if.stall), 32'd1);
    @(negedge clk);
    chk("ld_stall3", 32'(u_if.stall), 32'd1);
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = 32'd20;
    @(posedge clk);
    sb_q.push_back('{a: 5'd7, d: 32'd20});
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    chk("ld_done_rf_we",       32'(u_if.rf_we),       32'd1);
    chk("ld_done_stall",       32'(u_if.stall),       32'd0);
    chk("ld_done_mem_req",     32'(u_if.mem_req),     32'd0);
    chk("ld_done_issue_ready", 32'(u_if.issue_ready), 32'd1);

    // Minimum-latency load without reg_write: handshake completes, no write.
    start_load(32'h44, 5'd9, 1'b0);
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = 32'h77;
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    chk("ldnw_rf_we",       32'(u_if.rf_we),       32'd0);
    chk("ldnw_mem_req",     32'(u_if.mem_req),     32'd0);
    chk("ldnw_issue_ready", 32'(u_if.issue_ready), 32'd1);

    // Reset while waiting on memory; the late rvalid must be ignored.
    start_load(32'h80, 5'd4, 1'b1);
    chk("rmw_mem_req", 32'(u_if.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_mem_req",     32'(u_if.mem_req),     32'd0);
    chk("rmw_rst_mem_addr",    u_if.mem_addr,         32'd0);
    chk("rmw_rst_issue_ready", 32'(u_if.issue_ready), 32'd1);
    chk("rmw_rst_stall",       32'(u_if.stall),       32'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = 32'h99;
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    chk("rmw_rf_we",       32'(u_if.rf_we),       32'd0);
    chk("rmw_mem_req",     32'(u_if.mem_req),     32'd0);
    chk("rmw_issue_ready", 32'(u_if.issue_ready), 32'd1);

`ifdef WB_CTRL_TIMEOUT_EN
    // No response: mem_req for exactly TIMEOUT cycles, then a one-cycle err.
    start_load(32'h10, 5'd2, 1'b1);
    nreq = 0;
    nerr = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_if.mem_req === 1'b1) nreq++;
      if (u_if.err === 1'b1) begin
        nerr++;
        chk("to_rf_we",       32'(u_if.rf_we),       32'd0);
        chk("to_issue_ready", 32'(u_if.issue_ready), 32'd1);
        chk("to_mem_req",     32'(u_if.mem_req),     32'd0);
      end
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(nreq), 32'd4);
    chk("to_err_pulses", 32'(nerr), 32'd1);

    // Response in the final allowed cycle wins over the timeout.
    start_load(32'h20, 5'd6, 1'b1);
    repeat (3) @(negedge clk);
    chk("tol_mem_req", 32'(u_if.mem_req), 32'd1);
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = 32'hABCD;
    @(posedge clk);
    sb_q.push_back('{a: 5'd6, d: 32'hABCD});
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    chk("tol_err",   32'(u_if.err),   32'd0);
    chk("tol_rf_we", 32'(u_if.rf_we), 32'd1);
    @(negedge clk);
    chk("tol_err2", 32'(u_if.err), 32'd0);
`else
    nreq = 0;
    nerr = 0;
    start_load(32'h10, 5'd2, 1'b1);
    repeat (8) @(negedge clk);
    chk("nto_mem_req_held", 32'(u_if.mem_req), 32'd1);
    chk("nto_err",          32'(u_if.err),     32'd0);
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = 32'h1111;
    @(posedge clk);
    sb_q.push_back('{a: 5'd2, d: 32'h1111});
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    chk("nto_rf_we", 32'(u_if.rf_we), 32'd1);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule
